// File: rtl/spi_p2s_master.sv
// SPI mode-0 master: shifts one 40-bit register-access frame (addr, rw, 6 idle, data) out MSB first.
// Define SPI_MASTER_READ_EN to transmit rw and capture read data from spi_miso; otherwise every frame is a write.
module spi_p2s_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [16:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        spi_clk,
  output logic        spi_ss_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [5:0]      bit_q, bit_d;
  logic [39:0]     sreg_q, sreg_d;
  logic            sclk_q, sclk_d;
  logic            ss_n_q, ss_n_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept;
  logic            half_hit, gap_hit;
  logic            rw_eff;
  logic [39:0]     frame;

`ifdef SPI_MASTER_READ_EN
  logic            rd_q, rd_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     rdata_q, rdata_d;
  assign rw_eff = rw;
`else
  logic            unused_inputs;
  assign rw_eff        = 1'b0;
  assign unused_inputs = ^{rw, spi_miso};
`endif

  // Reads carry zeros in the data slots; the slave drives MISO there instead.
  assign frame    = {addr, rw_eff, 6'b0, (rw_eff ? 16'h0000 : wdata)};
  assign half_hit = (hcnt_q == HW'(CLK_DIV - 1));
  assign gap_hit  = (gcnt_q == GW'(CS_GAP - 1));

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
`ifdef SPI_MASTER_READ_EN
    rd_d    = rd_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
`endif
    case (state_q)
      S_IDLE: accept = start;
      S_SETUP: begin
        if (half_hit) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_SHIFT: begin
        if (half_hit) begin
          hcnt_d = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (bit_q == 6'd39) begin
              state_d = S_HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q + 6'd1;
              mosi_d = sreg_q[39];
              sreg_d = {sreg_q[38:0], 1'b0};
            end
          end
`ifdef SPI_MASTER_READ_EN
          else if (bit_q >= 6'd24) begin
            rx_d = {rx_q[14:0], spi_miso};
          end
`endif
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_HOLD: begin
        if (half_hit) begin
          state_d = S_GAP;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          gcnt_d  = '0;
`ifdef SPI_MASTER_READ_EN
          if (rd_q) rdata_d = rx_q;
`endif
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_GAP: begin
        // The edge that ends the gap may already accept the next request.
        if (gap_hit) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          accept  = start;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_SETUP;
      hcnt_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
      ss_n_d  = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = frame[39];
      sreg_d  = {frame[38:0], 1'b0};
`ifdef SPI_MASTER_READ_EN
      rd_d    = rw_eff;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_MASTER_READ_EN
      rd_q    <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SPI_MASTER_READ_EN
      rd_q    <= rd_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_clk  = sclk_q;
  assign spi_ss_n = ss_n_q;
  assign spi_mosi = mosi_q;
`ifdef SPI_MASTER_READ_EN
  assign rdata    = rdata_q;
`else
  assign rdata    = 16'h0000;
`endif

  a_done_ss: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> ss_n_q);
  a_sclk_ss: assert property (@(posedge clk) disable iff (!rst_n) sclk_q |-> !ss_n_q);
  a_bit_rng: assert property (@(posedge clk) disable iff (!rst_n) bit_q <= 6'd39);

endmodule

// File: tb/tb_spi_p2s_master.sv
// Randomised bench for spi_p2s_master: observes the serial pins, rebuilds each frame and
// compares it with a slot-by-slot model of the frame format and its timing.
module tb_spi_p2s_master;
  localparam int D = 2, G = 4;
`ifdef SPI_MASTER_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0, rw = 1'b0;
  logic [16:0] addr = '0;
  logic [15:0] wdata = '0, mword = '0, exp_rd = '0;
  logic busy, done, sclk, ss_n, mosi, miso;
  logic busy1, done1, sclk1, ss_n1, mosi1;
  logic miso1 = 1'b0;
  logic [15:0] rdata, rdata1;
  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_p2s_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .spi_clk(sclk), .spi_ss_n(ss_n),
    .spi_mosi(mosi), .spi_miso(miso));

  spi_p2s_master #(.CLK_DIV(1), .CS_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .spi_clk(sclk1), .spi_ss_n(ss_n1),
    .spi_mosi(mosi1), .spi_miso(miso1));

  // Pin monitor for dut, sampled mid-cycle; also plays the slave's MISO side.
  logic ps = 1'b0, pss = 1'b1;
  int rises = 0, fslot = 0, ss_bad = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0;
  logic rmosi [40];
  int   rcyc  [40];
  always @(negedge clk) begin
    ps  <= sclk;
    pss <= ss_n;
    if (!ss_n && pss) begin
      rises <= 0; fslot <= 0; fall_cyc <= cyc;
    end else if (sclk && !ps) begin
      if (rises < 40) begin rmosi[rises] <= mosi; rcyc[rises] <= cyc; end
      rises <= rises + 1;
    end else if (!sclk && ps) begin
      fslot <= fslot + 1;
    end
    if (rst_n && (ss_n != pss) && (sclk || ps)) ss_bad <= ss_bad + 1;
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
  end

  always_comb begin
    miso = 1'b0;
    if (fslot >= 24 && fslot < 40) miso = mword[39 - fslot];
  end

  logic ps1 = 1'b0, pss1 = 1'b1;
  int rises1 = 0, done_cyc1 = 0, fall_cyc1 = 0;
  logic rmosi1 [40];
  int   rcyc1  [40];
  always @(negedge clk) begin
    ps1  <= sclk1;
    pss1 <= ss_n1;
    if (!ss_n1 && pss1) begin
      rises1 <= 0; fall_cyc1 <= cyc;
    end else if (sclk1 && !ps1) begin
      if (rises1 < 40) begin rmosi1[rises1] <= mosi1; rcyc1[rises1] <= cyc; end
      rises1 <= rises1 + 1;
    end
    if (done1) done_cyc1 <= cyc;
  end

  // Reference: value of frame slot k straight from the frame layout.
  function automatic logic exp_slot(input logic [16:0] a, input logic r, input logic [15:0] w, input int k);
    logic re;
    re = r & RD_EN;
    if (k < 17) return a[16 - k];
    if (k == 17) return re;
    if (k < 24) return 1'b0;
    return re ? 1'b0 : w[39 - k];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic launch(input logic r, input logic [16:0] a, input logic [15:0] w,
                        input logic [15:0] mw, output int t0);
    wait_idle();
    @(negedge clk);
    rw = r; addr = a; wdata = w; mword = mw; start = 1'b1;
    @(negedge clk);
    start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (sclk !== 1'b0)  begin fails++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    tests++; if (ss_n !== 1'b1)  begin fails++; $display("FAIL rst_ss_n: got %b want 1", ss_n); end
    tests++; if (mosi !== 1'b0)  begin fails++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)  begin fails++; $display("FAIL rst_done: got %b want 0", done); end
    tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_fixed();
    int t0, n, bad_bit, bad_t;
    launch(1'b0, 17'h10005, 16'hA5C3, 16'h0, t0);
    tests++; if (ss_n !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wr_t0: ss_n=%b busy=%b want 0/1", ss_n, busy); end
    wait_done(n);
    tests++; if (done_cyc !== t0 + 81 * D) begin fails++; $display("FAIL wr_done_cycle: got T0+%0d want T0+%0d", done_cyc - t0, 81 * D); end
    tests++; if (rises !== 40) begin fails++; $display("FAIL wr_rises: got %0d want 40", rises); end
    bad_bit = 0; bad_t = 0;
    for (int k = 0; k < 40; k++) begin
      if (rmosi[k] !== exp_slot(17'h10005, 1'b0, 16'hA5C3, k)) bad_bit++;
      if (rcyc[k] !== t0 + (2 * k + 1) * D) bad_t++;
    end
    tests++; if (bad_bit != 0) begin fails++; $display("FAIL wr_mosi_bits: %0d wrong slots, want 0", bad_bit); end
    tests++; if (bad_t != 0) begin fails++; $display("FAIL wr_rise_times: %0d wrong rises, want 0", bad_t); end
    tests++; if (rdata !== exp_rd) begin fails++; $display("FAIL wr_rdata: got %h want %h", rdata, exp_rd); end
    tests++; if (ss_n !== 1'b1 || fall_cyc !== t0) begin fails++; $display("FAIL wr_ss: ss_n=%b fall T0+%0d, want 1 and T0+0", ss_n, fall_cyc - t0); end
    while (cyc < t0 + 81 * D + G - 1) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_gap: got %b want 1", busy); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_read_fixed();
    int t0, n;
    launch(1'b1, 17'h00003, 16'hBEEF, 16'h1234, t0);
    wait_done(n);
    if (RD_EN) exp_rd = 16'h1234;
    tests++; if (rdata !== exp_rd) begin fails++; $display("FAIL rd_rdata: got %h want %h", rdata, exp_rd); end
    tests++; if (rmosi[17] !== RD_EN) begin fails++; $display("FAIL rd_slot17: got %b want %b", rmosi[17], RD_EN); end
    tests++; if (done_cyc !== t0 + 81 * D) begin fails++; $display("FAIL rd_done_cycle: got T0+%0d want T0+%0d", done_cyc - t0, 81 * D); end
  endtask

  task automatic test_random();
    int t0, n, bad;
    logic r; logic [16:0] a; logic [15:0] w, mw;
    for (int i = 0; i < 8; i++) begin
      r = 1'($urandom_range(0, 1)); a = 17'($urandom); w = 16'($urandom); mw = 16'($urandom);
      launch(r, a, w, mw, t0);
      wait_done(n);
      if (r && RD_EN) exp_rd = mw;
      bad = 0;
      for (int k = 0; k < 40; k++) if (rmosi[k] !== exp_slot(a, r, w, k)) bad++;
      tests++; if (bad != 0 || rises !== 40) begin fails++; $display("FAIL rand_frame%0d: %0d bad slots, %0d rises, want 0 and 40", i, bad, rises); end
      tests++; if (rdata !== exp_rd) begin fails++; $display("FAIL rand_rdata%0d: got %h want %h", i, rdata, exp_rd); end
      tests++; if (done_cyc !== t0 + 81 * D) begin fails++; $display("FAIL rand_done%0d: got T0+%0d want T0+%0d", i, done_cyc - t0, 81 * D); end
    end
    tests++; if (ss_bad !== 0) begin fails++; $display("FAIL ss_while_sclk: %0d events, want 0", ss_bad); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, n, dc;
    launch(1'b0, 17'h0AAAA, 16'h5555, 16'h0, t0);
    while (cyc < t0 + 9) @(negedge clk);
    start = 1'b1; addr = 17'h1FFFF;
    @(negedge clk);
    start = 1'b0;
    #1; dc = done_cnt;
    wait_done(n);
    tests++; if (done_cyc !== t0 + 81 * D || fall_cyc !== t0 || rises !== 40) begin
      fails++; $display("FAIL ignore_midframe: done T0+%0d fall T0+%0d rises %0d, want %0d/0/40", done_cyc - t0, fall_cyc - t0, rises, 81 * D); end
    while (cyc < t0 + 81 * D + G - 2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    tests++; if (ss_n !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL ignore_gap: ss_n=%b busy=%b want 1/1", ss_n, busy); end
    @(negedge clk);
    start = 1'b0; t1 = cyc;
    tests++; if (ss_n !== 1'b0 || busy !== 1'b1 || t1 !== t0 + 81 * D + G) begin
      fails++; $display("FAIL accept_gap_end: ss_n=%b busy=%b at T0+%0d want 0/1 at T0+%0d", ss_n, busy, t1 - t0, 81 * D + G); end
    wait_done(n);
    tests++; if (done_cyc !== t1 + 81 * D || done_cnt !== dc + 2) begin
      fails++; $display("FAIL b2b_done: T1+%0d count %0d want T1+%0d count %0d", done_cyc - t1, done_cnt - dc, 81 * D, 2); end
  endtask

  task automatic test_reset_mid();
    int t0, n, dc;
    launch(1'b1, 17'($urandom), 16'($urandom), 16'hFFFF, t0);
    while (cyc < t0 + 50) @(negedge clk);
    #1; dc = done_cnt;
    rst_n = 1'b0; exp_rd = 16'h0;
    #1;
    tests++; if (ss_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0 || rdata !== 16'h0) begin
      fails++; $display("FAIL midrst_outputs: ss_n=%b sclk=%b busy=%b mosi=%b rdata=%h", ss_n, sclk, busy, mosi, rdata); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    tests++; if (done_cnt !== dc) begin fails++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - dc); end
    launch(1'b0, 17'h1C3A5, 16'h0F0F, 16'h0, t0);
    wait_done(n);
    tests++; if (rises !== 40 || done_cyc !== t0 + 81 * D) begin
      fails++; $display("FAIL midrst_next: rises %0d done T0+%0d want 40 and T0+%0d", rises, done_cyc - t0, 81 * D); end
  endtask

  task automatic test_fast_div1();
    int t0, n, bad_t, bad_b;
    logic [16:0] a; logic [15:0] w;
    a = 17'($urandom); w = 16'($urandom);
    @(negedge clk);
    rw = 1'b0; addr = a; wdata = w; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; t0 = cyc;
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    #1;
    tests++; if (done_cyc1 !== t0 + 81 || busy1 !== 1'b1) begin fails++; $display("FAIL div1_done: got T0+%0d busy %b want T0+81 busy 1", done_cyc1 - t0, busy1); end
    tests++; if (rises1 !== 40 || fall_cyc1 !== t0) begin fails++; $display("FAIL div1_rises: got %0d fall T0+%0d want 40 and T0+0", rises1, fall_cyc1 - t0); end
    bad_t = 0; bad_b = 0;
    for (int k = 0; k < 40; k++) begin
      if (rcyc1[k] !== t0 + 2 * k + 1) bad_t++;
      if (rmosi1[k] !== exp_slot(a, 1'b0, w, k)) bad_b++;
    end
    tests++; if (bad_t != 0 || bad_b != 0) begin fails++; $display("FAIL div1_frame: %0d bad rise times %0d bad bits want 0", bad_t, bad_b); end
    @(negedge clk);
    tests++; if (busy1 !== 1'b0 || rdata1 !== 16'h0) begin fails++; $display("FAIL div1_busy_fall: busy %b rdata %h want 0/0000", busy1, rdata1); end
  endtask

  initial begin
    test_reset();
    test_write_fixed();
    test_read_fixed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_fast_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
